// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU opcodes, multiplier FSM states and operand helper shared by the EX stage
package cpu_pkg;
  localparam logic [3:0] ALU_MUL   = 4'b0101;
  localparam logic [3:0] ALU_MULH  = 4'b0110;
  localparam logic [3:0] ALU_MULHU = 4'b0111;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction
endpackage

// File: rtl/mul_stall_unit_if.sv
// mul_stall_unit_if: EX-stage multiply request and stall/result signals between decoder and multiplier
interface mul_stall_unit_if;
  logic        ex_valid;
  logic [3:0]  aluop;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        stall_EX;
  logic [31:0] mul_result;
  logic        result_valid;
  logic        busy;
  modport master (output ex_valid, aluop, rs1_val, rs2_val, flush, input stall_EX, mul_result, result_valid, busy);
  modport slave (input ex_valid, aluop, rs1_val, rs2_val, flush, output stall_EX, mul_result, result_valid, busy);
endinterface

// File: rtl/mul_iter_dp.sv
// mul_iter_dp: shift-add accumulator consuming BITS_PER_CYCLE multiplier bits per step; MUL_EARLY_OUT_EN exposes rest_zero
module mul_iter_dp #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MUL_EARLY_OUT_EN
  output logic        rest_zero,
`endif
  output logic [63:0] acc
);
  logic [63:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  // load operands on start, otherwise add the current partial product and shift
  always_comb begin
    acc_d = load ? '0 : step ? acc_q + mcand_q * 64'(mplier_q[BITS_PER_CYCLE-1:0]) : acc_q;
    mcand_d = load ? {32'b0, a} : step ? mcand_q << BITS_PER_CYCLE : mcand_q;
    mplier_d = load ? b : step ? mplier_q >> BITS_PER_CYCLE : mplier_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
    end else begin
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
    end
  end
`ifdef MUL_EARLY_OUT_EN
  assign rest_zero = (mplier_q >> BITS_PER_CYCLE) == '0;
`endif
  assign acc = acc_q;
endmodule

// File: rtl/mul_stall_unit.sv
// mul_stall_unit: iterative MUL/MULH/MULHU with EX stall generation; define MUL_EARLY_OUT_EN to finish once remaining multiplier bits are zero
module mul_stall_unit
  import cpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst,
  mul_stall_unit_if.slave bus
);
  localparam int N = 32 / BITS_PER_CYCLE;
  mul_state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic neg_q, neg_d;
  logic mulh, is_mul, start, step, last;
  logic [31:0] a, b;
  logic [63:0] acc, p;
`ifdef MUL_EARLY_OUT_EN
  logic rest_zero;
`endif
  mul_iter_dp #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_dp (
    .clk(clk),
    .rst(rst),
    .load(start),
    .step(step),
    .a(a),
    .b(b),
`ifdef MUL_EARLY_OUT_EN
    .rest_zero(rest_zero),
`endif
    .acc(acc)
  );
  // detect a multiply, choose operands (magnitudes only for MULH) and sequence IDLE->BUSY->DONE
  always_comb begin
    mulh = bus.aluop == ALU_MULH;
    is_mul = bus.ex_valid && (bus.aluop == ALU_MUL || mulh || bus.aluop == ALU_MULHU);
    start = state_q == IDLE && is_mul && !bus.flush;
    step = state_q == BUSY && !bus.flush;
`ifdef MUL_EARLY_OUT_EN
    last = cnt_q == 5'(N - 1) || rest_zero;
`else
    last = cnt_q == 5'(N - 1);
`endif
    a = mulh ? abs32(bus.rs1_val) : bus.rs1_val;
    b = mulh ? abs32(bus.rs2_val) : bus.rs2_val;
    state_d = start ? BUSY : step ? (last ? DONE : BUSY) : IDLE;
    cnt_d = start ? '0 : step ? cnt_q + 5'd1 : cnt_q;
    op_d = start ? bus.aluop : op_q;
    neg_d = start ? mulh && (bus.rs1_val[31] ^ bus.rs2_val[31]) : neg_q;
  end
  // control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      neg_q <= neg_d;
    end
  end
  // stall while detecting or iterating; present the signed-corrected word only in DONE
  always_comb begin
    p = neg_q ? -acc : acc;
    bus.stall_EX = start || step;
    bus.result_valid = state_q == DONE && !bus.flush;
    bus.mul_result = state_q == DONE ? (op_q == ALU_MUL ? p[31:0] : p[63:32]) : '0;
    bus.busy = state_q != IDLE;
  end
endmodule

// File: tb/tb_mul_stall_unit.sv
// tb_mul_stall_unit: scoreboard bench for mul_stall_unit with directed and random multiplies
module tb_mul_stall_unit;
  import cpu_pkg::*;
  localparam int BPC = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic prev_rv = 1'b0;
  mul_stall_unit_if bus();
  mul_stall_unit #(.BITS_PER_CYCLE(BPC)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    logic [63:0] up;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    if (op == ALU_MUL) return up[31:0];
    if (op == ALU_MULHU) return up[63:32];
    return sp[63:32];
  endfunction

  function automatic int exp_stall(input logic [3:0] op, input logic [31:0] b);
    int busy_cycles;
    logic [31:0] m;
    busy_cycles = 32 / BPC;
    m = (op == ALU_MULH && b[31]) ? -b : b;
`ifdef MUL_EARLY_OUT_EN
    busy_cycles = 1;
    while ((m >> (busy_cycles * BPC)) != 0) busy_cycles++;
`endif
    if (m === 32'hx) busy_cycles = 0;
    return busy_cycles + 1;
  endfunction

  // monitor: every result_valid pops one expectation and must last a single cycle
  always @(negedge clk) begin
    #2;
    if (!rst && bus.result_valid) begin
      if (exp_q.size() == 0) chk("unexpected_result", bus.mul_result, 32'hx);
      else chk("mul_result", bus.mul_result, exp_q.pop_front());
      if (prev_rv) chk("result_single_cycle", 32'(prev_rv), 32'd0);
    end
    prev_rv = !rst && bus.result_valid;
  end

  task automatic run_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int cnt = 0;
    bit done = 0;
    exp_q.push_back(model(op, a, b));
    bus.ex_valid = 1'b1;
    bus.aluop = op;
    bus.rs1_val = a;
    bus.rs2_val = b;
    for (int i = 0; i < 100 && !done; i++) begin
      #2;
      if (bus.result_valid) done = 1;
      else begin
        if (bus.stall_EX) cnt++;
        @(negedge clk);
      end
    end
    if (!done) chk("result_timeout", 32'd0, 32'd1);
    chk("stall_cycles", 32'(cnt), 32'(exp_stall(op, b)));
    bus.ex_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.ex_valid = 1'b0;
    bus.aluop = 4'd0;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_stall", 32'(bus.stall_EX), 32'd0);
    chk("rst_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", bus.mul_result, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_mul(ALU_MUL, 32'd7, 32'd6);
    @(negedge clk);
    run_mul(ALU_MULH, 32'hFFFFFFFF, 32'h2);
    @(negedge clk);
    run_mul(ALU_MUL, 32'hFFFFFFFF, 32'h2);
    @(negedge clk);
    run_mul(ALU_MULH, 32'h80000000, 32'h80000000);
    @(negedge clk);
    run_mul(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    run_mul(ALU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    run_mul(ALU_MUL, 32'd3, 32'd5);
    @(negedge clk);
    run_mul(ALU_MUL, 32'd5, 32'd0);
    // flush on the 5th BUSY cycle
    @(negedge clk);
    bus.ex_valid = 1'b1;
    bus.aluop = ALU_MUL;
    bus.rs1_val = 32'd9;
    bus.rs2_val = 32'hFFFF;
    repeat (5) @(negedge clk);
    bus.flush = 1'b1;
    #2;
    chk("flush_stall", 32'(bus.stall_EX), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.ex_valid = 1'b0;
    #2;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_valid", 32'(bus.result_valid), 32'd0);
    @(negedge clk);
    run_mul(ALU_MUL, 32'd3, 32'd4);
    // reset mid-BUSY
    @(negedge clk);
    bus.ex_valid = 1'b1;
    bus.aluop = ALU_MULHU;
    bus.rs1_val = 32'h1234;
    bus.rs2_val = 32'hFFFFFFFF;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("midrst_stall", 32'(bus.stall_EX), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_valid", 32'(bus.result_valid), 32'd0);
    chk("midrst_result", bus.mul_result, 32'd0);
    // back-to-back
    @(negedge clk);
    run_mul(ALU_MUL, 32'd2, 32'd3);
    @(negedge clk);
    run_mul(ALU_MUL, 32'd4, 32'd5);
    // non-multiply instructions never stall
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.ex_valid = 1'b1;
      bus.aluop = 4'(i < 3 ? i : i + 5);
      bus.rs1_val = $urandom;
      bus.rs2_val = $urandom;
      #2;
      chk("nonmul_stall", 32'(bus.stall_EX), 32'd0);
      chk("nonmul_busy", 32'(bus.busy), 32'd0);
    end
    @(negedge clk);
    bus.ex_valid = 1'b0;
    bus.aluop = ALU_MUL;
    #2;
    chk("bubble_stall", 32'(bus.stall_EX), 32'd0);
    // random multiplies with random idle gaps
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      run_mul(4'(ALU_MUL + 4'($urandom_range(0, 2))), rand_operand(), rand_operand());
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
